// File: rtl/i2c_target_if.sv
// Peripheral-bus slot between the CPU bus decoder and the I2C target register bank.
// Latency: one-cycle acknowledge pulse with registered read data.
// Backpressure: none; every decoded request is answered on the following cycle.
interface i2c_target_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [7:0]  iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a byte register bank, pointer auto-increment, shared with the CPU bus.
// Latency: CPU access acked 1 cycle after request; I2C decisions ~3 cycles after SCL edges.
// Backpressure: none (no clock stretching); optional macro I2C_TGT_IRQ_EN adds irq/irq_en.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NUM_REGS    = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
`ifdef I2C_TGT_IRQ_EN
  output logic irq,
`endif
  i2c_target_if.slave bus
);
  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0]    scl_q, sda_q;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [7:0]    shift_q;
  logic          rw_q;
  logic [PW-1:0] ptr_q;
  logic          sda_oe_q;
  logic [7:0]    bank_q [NUM_REGS];
  logic          wr_flag_q, rd_seen_q;
  logic          ready_q;
  logic [31:0]   rdata_q;
`ifdef I2C_TGT_IRQ_EN
  logic          wr_pend_q;
  logic          irq_en_q;
`endif

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    rx_byte, cur_byte;
  logic          req, is_bank, busy;
  logic [PW-1:0] bidx;
  logic [31:0]   rd_word;

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rx_byte   = {shift_q[6:0], sda_q[1]};
  assign cur_byte  = bank_q[ptr_q];

  assign req     = bus.iomem_valid & ~ready_q;
  assign is_bank = ({1'b0, bus.iomem_addr} < 9'(NUM_REGS)) && (bus.iomem_addr[1:0] == 2'b00);
  assign bidx    = bus.iomem_addr[PW-1:0];
  assign busy    = (state_q != IDLE) && (state_q != WAIT_STOP);

  assign sda_oe          = sda_oe_q;
  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
`ifdef I2C_TGT_IRQ_EN
  assign irq = irq_en_q & wr_flag_q;
`endif

  // CPU read mux: little-endian bank words, status word, optional control word
  always_comb begin
    rd_word = 32'd0;
    if (is_bank) begin
      rd_word = {bank_q[bidx + PW'(3)], bank_q[bidx + PW'(2)], bank_q[bidx + PW'(1)], bank_q[bidx]};
    end else if (bus.iomem_addr == 8'h40) begin
      rd_word[0]       = busy;
      rd_word[1]       = wr_flag_q;
      rd_word[2]       = rd_seen_q;
      rd_word[8 +: PW] = ptr_q;
    end
`ifdef I2C_TGT_IRQ_EN
    else if (bus.iomem_addr == 8'h44) begin
      rd_word[8] = irq_en_q;
    end
`endif
  end

  // Pad conditioning, protocol FSM, register bank and CPU slot; the I2C side is
  // evaluated after the CPU side so its bank writes and flag sets win collisions.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_flag_q <= 1'b0;
      rd_seen_q <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'd0;
`ifdef I2C_TGT_IRQ_EN
      wr_pend_q <= 1'b0;
      irq_en_q  <= 1'b0;
`endif
    end else begin
      scl_q   <= {scl_q[1:0], scl_in};
      sda_q   <= {sda_q[1:0], sda_in};
      ready_q <= req;
      rdata_q <= req ? rd_word : 32'd0;

      if (req && (bus.iomem_wstrb != 4'd0)) begin
        if (is_bank) begin
          for (int k = 0; k < 4; k++) begin
            if (bus.iomem_wstrb[k]) bank_q[bidx + PW'(k)] <= bus.iomem_wdata[8*k +: 8];
          end
        end else if (bus.iomem_addr == 8'h40 && bus.iomem_wstrb[0]) begin
          if (bus.iomem_wdata[1]) wr_flag_q <= 1'b0;
          if (bus.iomem_wdata[2]) rd_seen_q <= 1'b0;
        end
`ifdef I2C_TGT_IRQ_EN
        else if (bus.iomem_addr == 8'h44 && bus.iomem_wstrb[1]) begin
          irq_en_q <= bus.iomem_wdata[8];
        end
`endif
      end

      if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
`ifdef I2C_TGT_IRQ_EN
        if (wr_pend_q) wr_flag_q <= 1'b1;
        wr_pend_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_q <= 4'd0;
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state_q <= ADDR_ACK;
                rw_q    <= rx_byte[0];
                if (rx_byte[0]) rd_seen_q <= 1'b1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          // First falling edge starts the ACK clock, the second one ends it
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (rw_q) begin
              state_q  <= RDATA;
              shift_q  <= cur_byte;
              sda_oe_q <= ~cur_byte[7];
              cnt_q    <= 4'd0;
            end else begin
              state_q  <= PTR;
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
            end
          end
          PTR: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ptr_q   <= rx_byte[PW-1:0];
              state_q <= PTR_ACK;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              state_q  <= WDATA;
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
            end
          end
          WDATA: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              bank_q[ptr_q] <= rx_byte;
              ptr_q         <= ptr_q + 1'b1;
              state_q       <= WDATA_ACK;
`ifdef I2C_TGT_IRQ_EN
              wr_pend_q <= 1'b1;
`else
              wr_flag_q <= 1'b1;
`endif
            end
          end
          // Shift on the rising edge, present the next bit on the falling edge
          RDATA: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], 1'b0};
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RDATA_ACK;
                cnt_q    <= 4'd0;
              end else begin
                sda_oe_q <= ~shift_q[7];
              end
            end
          end
          // cnt_q=1 marks a master ACK seen on the rising edge
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_q[1]) begin
                ptr_q <= ptr_q + 1'b1;
                cnt_q <= 4'd1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && cnt_q == 4'd1) begin
              state_q  <= RDATA;
              shift_q  <= cur_byte;
              sda_oe_q <= ~cur_byte[7];
              cnt_q    <= 4'd0;
            end
          end
          IDLE, WAIT_STOP: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master plus CPU bus driver, checked against a
// transaction-level model of the bank, pointer and status flags.
module tb_i2c_target;
  localparam int N = 16;
  localparam int T = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe;
  wire  sda_line = m_sda & ~sda_oe;
`ifdef I2C_TGT_IRQ_EN
  logic irq;
`endif

  i2c_target_if bus();

  i2c_target #(.TARGET_ADDR(7'h42), .NUM_REGS(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .scl_in (m_scl),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
`ifdef I2C_TGT_IRQ_EN
    .irq    (irq),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [7:0]  m_bank [N];
  int          m_ptr;
  logic        m_wr, m_rd, m_busy, m_pend, m_irq_en;
  logic [7:0]  wq[$];
  logic [7:0]  rd_log[$];
  logic [31:0] exp_q[$];
  string       nm_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic a, input logic e);
    check(nm, {31'd0, a}, {31'd0, e});
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bank[i] = 8'd0;
    m_ptr = 0; m_wr = 0; m_rd = 0; m_busy = 0; m_pend = 0; m_irq_en = 0;
  endtask

  task automatic model_stop();
    m_busy = 1'b0;
`ifdef I2C_TGT_IRQ_EN
    if (m_pend) m_wr = 1'b1;
`endif
    m_pend = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] a);
    logic [31:0] w;
    w = 32'd0;
    if (int'(a) < N && a[1:0] == 2'b00) begin
      w = {m_bank[a+3], m_bank[a+2], m_bank[a+1], m_bank[a]};
    end else if (a == 8'h40) begin
      w[0] = m_busy; w[1] = m_wr; w[2] = m_rd; w[13:8] = 6'(m_ptr);
    end
`ifdef I2C_TGT_IRQ_EN
    else if (a == 8'h44) w[8] = m_irq_en;
`endif
    return w;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every CPU read response is compared with the value predicted at issue time
  always @(negedge clk) begin
    if (resetn && bus.iomem_ready && exp_q.size() > 0)
      check(nm_q.pop_front(), bus.iomem_rdata, exp_q.pop_front());
  end

  task automatic cpu_xfer(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd);
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = a; bus.iomem_wstrb = ws; bus.iomem_wdata = wd;
    @(negedge clk);
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'd0;
    check1("ready_pulse", bus.iomem_ready, 1'b1);
    @(negedge clk);
    check1("ready_single", bus.iomem_ready, 1'b0);
  endtask

  task automatic cpu_read(input logic [7:0] a);
    exp_q.push_back(model_word(a)); nm_q.push_back("cpu_rd_model");
    cpu_xfer(a, 4'd0, 32'd0);
  endtask

  task automatic cpu_read_lit(input logic [7:0] a, input logic [31:0] lit, input string nm);
    exp_q.push_back(lit); nm_q.push_back(nm);
    cpu_xfer(a, 4'd0, 32'd0);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd);
    cpu_xfer(a, ws, wd);
    if (int'(a) < N && a[1:0] == 2'b00) begin
      for (int k = 0; k < 4; k++) if (ws[k]) m_bank[int'(a) + k] = wd[8*k +: 8];
    end else if (a == 8'h40 && ws[0]) begin
      if (wd[1]) m_wr = 1'b0;
      if (wd[2]) m_rd = 1'b0;
    end
`ifdef I2C_TGT_IRQ_EN
    else if (a == 8'h44 && ws[1]) m_irq_en = wd[8];
`endif
  endtask

  // Bit-level master; SDA only changes two cycles after SCL has fallen
  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_sda = 1'b0; wait_clk(T);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_sda = 1'b1; wait_clk(T);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; wait_clk(T);
    m_scl = 1'b1; wait_clk(T/2);
    s = sda_line; wait_clk(T/2);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    check1(nm, ~s, exp_ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      got[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  // Write transaction: pointer then the bytes queued in wq
  task automatic tx_write(input logic [7:0] ptr);
    i2c_start();
    write_byte(8'h84, 1'b1, "wr_addr_ack");
    m_busy = 1'b1;
    write_byte(ptr, 1'b1, "wr_ptr_ack");
    m_ptr = int'(ptr) % N;
    foreach (wq[i]) begin
      write_byte(wq[i], 1'b1, "wr_data_ack");
      m_bank[m_ptr] = wq[i];
      m_ptr = (m_ptr + 1) % N;
`ifdef I2C_TGT_IRQ_EN
      m_pend = 1'b1;
`else
      m_wr = 1'b1;
`endif
    end
    cpu_read(8'h40);
`ifdef I2C_TGT_IRQ_EN
    check1("irq_before_stop", irq, m_irq_en & m_wr);
`endif
    i2c_stop();
    model_stop();
`ifdef I2C_TGT_IRQ_EN
    check1("irq_after_stop", irq, m_irq_en & m_wr);
`endif
  endtask

  // Pointer write, repeated START, read n bytes (ACK all but the last)
  task automatic tx_read(input logic [7:0] ptr, input int n);
    logic [7:0] got, exp;
    i2c_start();
    write_byte(8'h84, 1'b1, "rd_waddr_ack");
    m_busy = 1'b1;
    write_byte(ptr, 1'b1, "rd_ptr_ack");
    m_ptr = int'(ptr) % N;
    i2c_start();
    write_byte(8'h85, 1'b1, "rd_addr_ack");
    m_rd = 1'b1;
    rd_log.delete();
    for (int k = 0; k < n; k++) begin
      exp = m_bank[m_ptr];
      read_byte(k != n - 1, got);
      check("rd_data", {24'd0, got}, {24'd0, exp});
      rd_log.push_back(got);
      if (k != n - 1) m_ptr = (m_ptr + 1) % N;
    end
    wait_clk(3);
    check1("rd_release_after_nack", sda_oe, 1'b0);
    i2c_stop();
    model_stop();
  endtask

  // Foreign address: no ACK, following byte ignored
  task automatic tx_badaddr(input logic [6:0] a7, input logic rw);
    i2c_start();
    write_byte({a7, rw}, 1'b0, "bad_addr_nack");
    cpu_read(8'h40);
    write_byte(8'h00, 1'b0, "wait_stop_nack");
    i2c_stop();
    model_stop();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a;
    logic [6:0] a7;
    logic [7:0] got;
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'd0; bus.iomem_addr = 8'd0; bus.iomem_wdata = 32'd0;
    model_reset();
    wait_clk(3);
    check1("rst_sda_oe", sda_oe, 1'b0);
    check1("rst_ready", bus.iomem_ready, 1'b0);
    check("rst_rdata", bus.iomem_rdata, 32'd0);
    resetn = 1'b1;
    wait_clk(4);
    cpu_read_lit(8'h40, 32'd0, "rst_status");
    cpu_read_lit(8'h0C, 32'd0, "rst_bank");

    // Write A5,5A at pointer 3
    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h5A);
    tx_write(8'h03);
    cpu_read_lit(8'h00, 32'hA500_0000, "t1_word0");
    cpu_read_lit(8'h04, 32'h0000_005A, "t1_word1");
    cpu_read_lit(8'h40, 32'h0000_0502, "t1_status");
    cpu_write(8'h40, 4'h1, 32'h2);

    // CPU fills bytes 0..3, master reads 3 of them back
    cpu_write(8'h00, 4'hF, 32'h4433_2211);
    tx_read(8'h00, 3);
    check("t2_byte0", {24'd0, rd_log[0]}, 32'h11);
    check("t2_byte1", {24'd0, rd_log[1]}, 32'h22);
    check("t2_byte2", {24'd0, rd_log[2]}, 32'h33);
    cpu_read_lit(8'h40, 32'h0000_0204, "t2_status");
    cpu_write(8'h40, 4'h1, 32'h4);

    // Foreign address 0x90
    tx_badaddr(7'h48, 1'b0);
    cpu_read_lit(8'h00, 32'h4433_2211, "t3_bank_kept");

    // Pointer wrap at the top of the bank
    wq.delete(); wq.push_back(8'hBB); wq.push_back(8'hCC);
    tx_write(8'h0F);
    cpu_read_lit(8'h0C, 32'hBB00_0000, "t4_top");
    cpu_read_lit(8'h00, 32'h4433_22CC, "t4_wrap");
    cpu_read_lit(8'h40, 32'h0000_0102, "t4_status");

    // Unmapped offsets
    cpu_write(8'h80, 4'hF, 32'hFFFF_FFFF);
    cpu_read_lit(8'h80, 32'd0, "unmapped");
    cpu_read_lit(8'h02, 32'd0, "misaligned");

    // Reset while driving a 0 data bit (bank[1]=0x22)
    i2c_start();
    write_byte(8'h85, 1'b1, "t5_addr_ack");
    wait_clk(4);
    check1("t5_driving", sda_oe, 1'b1);
    resetn = 1'b0;
    wait_clk(1);
    resetn = 1'b1;
    check1("t5_released", sda_oe, 1'b0);
    model_reset();
    i2c_start();
    write_byte(8'h84, 1'b1, "t5_post_reset_ack");
    m_busy = 1'b1;
    i2c_stop();
    model_stop();
    cpu_read_lit(8'h00, 32'd0, "t5_bank_cleared");

`ifdef I2C_TGT_IRQ_EN
    cpu_write(8'h44, 4'h2, 32'h100);
    cpu_read_lit(8'h44, 32'h100, "irq_en_rd");
    wq.delete(); wq.push_back(8'h77);
    tx_write(8'h02);
    check1("irq_set_lit", irq, 1'b1);
    cpu_write(8'h40, 4'h1, 32'h2);
    check1("irq_clear_lit", irq, 1'b0);
`else
    cpu_write(8'h44, 4'hF, 32'h100);
    cpu_read_lit(8'h44, 32'd0, "ctrl_absent");
`endif

    // Randomized transactions against the model
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          wq.delete();
          repeat ($urandom_range(1, 4)) wq.push_back(8'($urandom));
          tx_write(8'($urandom));
        end
        2: tx_read(8'($urandom), int'($urandom_range(1, 4)));
        3: begin
          do a7 = 7'($urandom); while (a7 == 7'h42);
          tx_badaddr(a7, 1'($urandom));
        end
        default: begin
          if ($urandom_range(0, 3) == 0) cpu_write(8'h40, 4'h1, $urandom);
          else cpu_write(8'($urandom_range(0, N/4 - 1) * 4), 4'($urandom), $urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        4: a = 8'h40;
        5: a = 8'($urandom);
        default: a = 8'($urandom_range(0, N/4 - 1) * 4);
      endcase
      cpu_read(a);
      cpu_read(8'h40);
    end

    got = 8'(exp_q.size());
    check("rd_queue_drained", {24'd0, got}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
